// File: rtl/tx_arbiter_pkg.sv
// Shared constants and types for the transaction-layer output arbiter.
// Holds link-state encodings, port geometry and the arbiter state type.
package tx_arbiter_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned IDXW   = 3;
    localparam int unsigned CNTW   = 16;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam logic [IDXW-1:0] LAST_RESET = IDXW'(NPORTS - 1);

    typedef enum logic {
        ARB_HOLD  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // (a + b) mod NPORTS for operands already in 0..NPORTS-1.
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] a,
                                                 input logic [IDXW-1:0] b);
        logic [IDXW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDXW+1)'(NPORTS)) begin
            s = s - (IDXW+1)'(NPORTS);
        end
        return s[IDXW-1:0];
    endfunction

    function automatic logic [NPORTS-1:0] idx_onehot(input logic [IDXW-1:0] i);
        logic [NPORTS-1:0] oh;
        oh = '0;
        for (int k = 0; k < int'(NPORTS); k++) begin
            if (i == IDXW'(k)) begin
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick5.sv
// Rotating priority encoder over five requesters: returns the first set bit
// of elig found scanning upward from start with wrap, plus a found flag.
module rr_pick5
    import tx_arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] elig,
    input  logic [IDXW-1:0]   start,
    output logic [IDXW-1:0]   sel,
    output logic              found
);

    logic [IDXW-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        pos   = '0;
        for (int off = int'(NPORTS) - 1; off >= 0; off--) begin
            pos = wrap_add(start, IDXW'(off));
            if (elig[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin grant generator feeding the output mux and FIFO pop strobes.
// Define TX_ARB_STRICT_PRIO_EN for fixed lowest-index-first priority.
module tx_arbiter
    import tx_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic [NPORTS-1:0] fifo_empty,
    input  logic              almost_full,
    output logic              req,
    output logic [IDXW-1:0]   idx,
    output logic [NPORTS-1:0] pop,
    output logic [CNTW-1:0]   grant_cnt
);

    arb_state_e        arb_q, arb_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NPORTS-1:0] pop_q, pop_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [NPORTS-1:0] excl;
    logic [NPORTS-1:0] elig;
    logic [IDXW-1:0]   start;
    logic [IDXW-1:0]   sel;
    logic              found;
    logic              en;

`ifndef TX_ARB_STRICT_PRIO_EN
    logic [IDXW-1:0]   last_q, last_d;
`endif

    // The port granted this cycle still shows a stale non-empty flag.
    always_comb begin
        excl = '0;
        if (arb_q == ARB_GRANT) begin
            excl = idx_onehot(idx_q);
        end
        elig = ~fifo_empty & ~excl;
    end

`ifdef TX_ARB_STRICT_PRIO_EN
    assign start = '0;
`else
    assign start = wrap_add(last_q, IDXW'(1));
`endif

    rr_pick5 u_pick (
        .elig  (elig),
        .start (start),
        .sel   (sel),
        .found (found)
    );

    assign en = (state == ST_IDLE) && !almost_full && found;

    always_comb begin
        arb_d = ARB_HOLD;
        idx_d = idx_q;
        pop_d = '0;
        cnt_d = cnt_q;
`ifndef TX_ARB_STRICT_PRIO_EN
        last_d = last_q;
`endif
        if (en) begin
            arb_d = ARB_GRANT;
            idx_d = sel;
            pop_d = idx_onehot(sel);
            cnt_d = cnt_q + CNTW'(1);
`ifndef TX_ARB_STRICT_PRIO_EN
            last_d = sel;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_q <= ARB_HOLD;
            idx_q <= '0;
            pop_q <= '0;
            cnt_q <= '0;
        end else begin
            arb_q <= arb_d;
            idx_q <= idx_d;
            pop_q <= pop_d;
            cnt_q <= cnt_d;
        end
    end

`ifndef TX_ARB_STRICT_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= LAST_RESET;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign req       = (arb_q == ARB_GRANT);
    assign idx       = idx_q;
    assign pop       = pop_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [4:0]  fifo_empty;
    logic        almost_full;
    logic        req;
    logic [2:0]  idx;
    logic [4:0]  pop;
    logic [15:0] grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_req, m_idx, m_cnt, m_last;

    tx_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .req         (req),
        .idx         (idx),
        .pop         (pop),
        .grant_cnt   (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a grant goes to the first non-empty port, other than the one
    // granted right now, in scan order; only in idle and without backpressure.
    always @(posedge clk or posedge reset) begin
        int pick;
        int p;
        bit hit;
        if (reset) begin
            m_req  <= 0;
            m_idx  <= 0;
            m_cnt  <= 0;
            m_last <= 4;
        end else begin
            hit  = 0;
            pick = 0;
            for (int k = 1; k <= 5; k++) begin
`ifdef TX_ARB_STRICT_PRIO_EN
                p = k - 1;
`else
                p = (m_last + k) % 5;
`endif
                if (!hit && fifo_empty[p] == 1'b0 && !(m_req == 1 && m_idx == p)) begin
                    hit  = 1;
                    pick = p;
                end
            end
            if (state == 4'b0100 && !almost_full && hit) begin
                m_req  <= 1;
                m_idx  <= pick;
                m_cnt  <= (m_cnt + 1) % 65536;
                m_last <= pick;
            end else begin
                m_req <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("req",       int'(req),       m_req);
        check("idx",       int'(idx),       m_idx);
        check("pop",       int'(pop),       m_req == 1 ? (1 << m_idx) : 0);
        check("grant_cnt", int'(grant_cnt), m_cnt);
        check("pop_onehot0", int'($onehot0(pop)), 1);
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int seq_rr[6];
        int seq_13[4];
        seq_rr = '{0, 1, 2, 3, 4, 0};
        seq_13 = '{1, 3, 1, 3};

        reset       = 1'b1;
        state       = 4'b0001;
        fifo_empty  = 5'b11111;
        almost_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_req", int'(req), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_pop", int'(pop), 0);
        check("rst_cnt", int'(grant_cnt), 0);

        // All five non-empty: plain rotation.
        state      = 4'b0100;
        fifo_empty = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_req", int'(req), 1);
            check("rr_idx", int'(idx), seq_rr[i]);
            check("rr_pop", int'(pop), 1 << seq_rr[i]);
        end
        check("rr_cnt", int'(grant_cnt), 6);

        // Asynchronous reset while a grant is live.
        #2 reset = 1'b1;
        #1;
        check("midrst_req", int'(req), 0);
        check("midrst_pop", int'(pop), 0);
        check("midrst_cnt", int'(grant_cnt), 0);

        // Lone port 2: granted every other cycle.
        @(negedge clk);
        fifo_empty = 5'b11011;
        reset      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lone_req", int'(req), (i % 2 == 0) ? 1 : 0);
            check("lone_pop", int'(pop), (i % 2 == 0) ? 5'b00100 : 0);
            if (req) check("lone_idx", int'(idx), 2);
        end

        // Not idle: no grants.
        state      = 4'b0010;
        fifo_empty = 5'b00000;
        pulse_reset();
        repeat (2) @(negedge clk);
        check("init_req", int'(req), 0);
        state = 4'b1000;
        repeat (2) @(negedge clk);
        check("act_req", int'(req), 0);
        check("act_pop", int'(pop), 0);
        check("act_cnt", int'(grant_cnt), 0);
        state = 4'b0100;
        @(negedge clk);
        check("idle_req", int'(req), 1);
        check("idle_idx", int'(idx), 0);

        // Backpressure after the first grant.
        almost_full = 1'b1;
        @(negedge clk);
        check("af_req0", int'(req), 0);
        @(negedge clk);
        check("af_req1", int'(req), 0);
        check("af_cnt", int'(grant_cnt), 1);
        almost_full = 1'b0;
        @(negedge clk);
        check("af_resume_req", int'(req), 1);
        check("af_resume_idx", int'(idx), 1);
        check("af_resume_cnt", int'(grant_cnt), 2);

        // Ports 1 and 3 only: alternate in both priority modes.
        fifo_empty = 5'b10101;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p13_req", int'(req), 1);
            check("p13_idx", int'(idx), seq_13[i]);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 7) begin
                state = 4'b0100;
            end else begin
                case ($urandom_range(0, 2))
                    0:       state = 4'b0001;
                    1:       state = 4'b0010;
                    default: state = 4'b1000;
                endcase
            end
            fifo_empty  = 5'($urandom);
            almost_full = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
